spi_command_engine: RTL and testbench

- Parametrised SPI master command engine; successor to the fixed 8-bit, fixed-mode SPI facade.
- Executes a stream of opcoded commands (transfer, CS assert, CS deassert, delay) from an upstream command FIFO/host bridge.
- Returns received data through a ready/valid response port.
- Contains its own shift engine; mode, bit order and SCLK rate are run-time configurable, word width is parametrised.

---
 rtl/spi_command_engine.sv | 180 ++++++++++++++++++
 tb/tb_spi_command_engine.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_command_engine.sv
// SPI master command engine: runs transfer / chip-select / delay commands from an
// upstream queue and returns each received word on a ready/valid response port.
module spi_command_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_lsb_first,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  output logic                  busy,
  output logic                  bp_mosi,
  input  logic                  bp_miso,
  output logic                  bp_clock,
  output logic                  bp_cs
);
  localparam int BCW = $clog2(2 * DATA_WIDTH);
  localparam int DLW = DATA_WIDTH + DIV_WIDTH;
  localparam logic [BCW-1:0] LAST_EDGE = BCW'(2 * DATA_WIDTH - 1);
  localparam logic [1:0] OP_XFER   = 2'd0;
  localparam logic [1:0] OP_CS_ON  = 2'd1;
  localparam logic [1:0] OP_CS_OFF = 2'd2;
  localparam logic [1:0] OP_DELAY  = 2'd3;

  typedef enum logic [2:0] {IDLE, CS, SHIFT, RESP, WAIT} state_t;
  state_t state, state_nxt;

  logic                  cpha, lsb_first;
  logic [DIV_WIDTH-1:0]  div, div_cnt;
  logic [BCW-1:0]        bit_cnt;
  logic [DLW-1:0]        dly_cnt, dly_load;
  logic [DATA_WIDTH-1:0] tx_sh, rx_sh, rx_in;
  logic                  accept, tick, last_edge, sample_edge, drive_edge;

  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] w,
                                                     input logic lsb);
    return lsb ? {1'b0, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b, input logic lsb);
    return lsb ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
  endfunction

  assign cmd_ready   = (state == IDLE) && !reset;
  assign accept      = cmd_valid && cmd_ready;
  assign tick        = (div_cnt == div);
  assign last_edge   = (bit_cnt == LAST_EDGE);
  // Even edge index = leading edge; sample on leading for cpha=0, trailing for cpha=1.
  assign sample_edge = (bit_cnt[0] == cpha);
  assign drive_edge  = !sample_edge && !(last_edge && !cpha);
  assign rx_in       = rx_shift(rx_sh, bp_miso, lsb_first);
  assign dly_load    = DLW'(cmd_data) * (DLW'(cfg_div) + DLW'(1));

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_XFER:   state_nxt = SHIFT;
            OP_CS_ON:  state_nxt = CS;
            OP_CS_OFF: state_nxt = CS;
            OP_DELAY:  state_nxt = WAIT;
            default:   state_nxt = IDLE;
          endcase
        end else begin
          state_nxt = IDLE;
        end
      end
      CS:    state_nxt = IDLE;
      SHIFT: begin
        if (tick && last_edge) state_nxt = RESP;
        else                   state_nxt = SHIFT;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
        else           state_nxt = RESP;
      end
      WAIT: begin
        if (dly_cnt <= DLW'(1)) state_nxt = IDLE;
        else                    state_nxt = WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath: config latch, SCLK/shift engine, response and delay counters
  always_ff @(posedge clock) begin
    if (reset) begin
      bp_cs     <= 1'b1;
      bp_clock  <= 1'b0;
      bp_mosi   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      cpha      <= 1'b0;
      lsb_first <= 1'b0;
      div       <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      dly_cnt   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          bp_clock <= cfg_cpol;
          if (accept) begin
            cpha      <= cfg_cpha;
            lsb_first <= cfg_lsb_first;
            div       <= cfg_div;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            rx_sh     <= '0;
            dly_cnt   <= dly_load;
            case (cmd_op)
              OP_XFER: begin
                // cpha=0 presents the first bit before the first edge.
                if (!cfg_cpha) begin
                  bp_mosi <= out_bit(cmd_data, cfg_lsb_first);
                  tx_sh   <= tx_shift(cmd_data, cfg_lsb_first);
                end else begin
                  tx_sh <= cmd_data;
                end
              end
              OP_CS_ON:  bp_cs <= 1'b0;
              OP_CS_OFF: bp_cs <= 1'b1;
              default: ;
            endcase
          end
        end
        SHIFT: begin
          if (tick) begin
            div_cnt  <= '0;
            bit_cnt  <= bit_cnt + BCW'(1);
            bp_clock <= ~bp_clock;
            if (sample_edge) rx_sh <= rx_in;
            if (drive_edge) begin
              bp_mosi <= out_bit(tx_sh, lsb_first);
              tx_sh   <= tx_shift(tx_sh, lsb_first);
            end
            if (last_edge) begin
              rsp_valid <= 1'b1;
              rsp_data  <= sample_edge ? rx_in : rx_sh;
            end
          end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        WAIT: dly_cnt <= dly_cnt - DLW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_command_engine.sv
// Directed bench for spi_command_engine: scoreboarded responses, SPI wire
// monitors and a mode-0 slave model with optional MISO/MOSI loopback.
module tb_spi_command_engine;
  logic       clock = 1'b0;
  logic       reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data, rsp_data, cfg_div;
  logic       cfg_cpol, cfg_cpha, cfg_lsb_first, busy;
  logic       bp_mosi, bp_miso, bp_clock, bp_cs;

  spi_command_engine #(.DATA_WIDTH(8), .DIV_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first), .cfg_div(cfg_div), .busy(busy), .bp_mosi(bp_mosi),
    .bp_miso(bp_miso), .bp_clock(bp_clock), .bp_cs(bp_cs)
  );

  always #5 clock = ~clock;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb_q[$];

  logic       slave_en, mon_clr, mon_first, slave_bit;
  logic [7:0] slave_word, mon_word;
  logic [3:0] fall_cnt, rise_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Mode-0 slave: presents MSB first, advances on each falling SCLK.
  always @(negedge bp_clock or posedge mon_clr) begin
    if (mon_clr) fall_cnt <= 4'd0;
    else if (fall_cnt < 4'd8) fall_cnt <= fall_cnt + 4'd1;
  end

  always_comb begin
    slave_bit = 1'b0;
    if (fall_cnt < 4'd8) slave_bit = slave_word[3'd7 - fall_cnt[2:0]];
  end

  assign bp_miso = slave_en ? slave_bit : bp_mosi;

  // MOSI as seen on rising SCLK
  always @(posedge bp_clock or posedge mon_clr) begin
    if (mon_clr) begin
      mon_word <= 8'h00; rise_cnt <= 4'd0; mon_first <= 1'b0;
    end else begin
      mon_word <= {mon_word[6:0], bp_mosi};
      rise_cnt <= rise_cnt + 4'd1;
      if (rise_cnt == 4'd0) mon_first <= bp_mosi;
    end
  end

  // Scoreboard: compare each handshaken response with the oldest expectation
  always @(negedge clock) begin
    #2;
    if (!reset && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb_q.size() == 0) check("sb_nonempty", 32'(sb_q.size()), 32'd1);
      else check("rsp_data", 32'(rsp_data), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    mon_clr = 1'b1; #1; mon_clr = 1'b0;
  endtask

  // Called on a negedge; returns on the negedge just after the acceptance edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    int guard = 0;
    cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && guard < 500) begin
      @(negedge clock); guard++;
    end
    check("issue_ready_timeout", 32'(guard < 500), 32'd1);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] tx, input logic [7:0] rx,
                          input int lat, input int hp);
    int cnt, t1, t2;
    logic prev;
    sb_q.push_back(rx);
    issue(2'd0, tx);
    if (!cfg_cpha) check({tag, "_first_mosi"}, 32'(bp_mosi), 32'(cfg_lsb_first ? tx[0] : tx[7]));
    cnt = 1; t1 = 0; t2 = 0; prev = bp_clock;
    while (rsp_valid !== 1'b1 && cnt < 5000) begin
      @(negedge clock); cnt++;
      if (bp_clock !== prev) begin
        prev = bp_clock;
        if (t1 == 0) t1 = cnt;
        else if (t2 == 0) t2 = cnt;
      end
    end
    check({tag, "_latency"}, 32'(cnt), 32'(lat));
    check({tag, "_half_period"}, 32'(t2 - t1), 32'(hp));
    check({tag, "_sclk_idle"}, 32'(bp_clock), 32'(cfg_cpol));
    @(negedge clock);
  endtask

  initial begin
    int cnt;
    logic ok_rdy, ok_dat;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00; rsp_ready = 1'b1;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_div = 8'd0;
    slave_en = 1'b0; slave_word = 8'h00; mon_clr = 1'b0;
    clear_mon();
    repeat (3) @(negedge clock);
    check("rst_bp_cs", 32'(bp_cs), 32'd1);
    check("rst_bp_clock", 32'(bp_clock), 32'd0);
    check("rst_bp_mosi", 32'(bp_mosi), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: CS assert, mode-0 transfer against slave 0x3C, CS deassert
    issue(2'd1, 8'h00);
    check("t1_cs_low", 32'(bp_cs), 32'd0);
    slave_en = 1'b1; slave_word = 8'h3C;
    clear_mon();
    run_xfer("t1", 8'hA5, 8'h3C, 17, 1);
    check("t1_mosi_word", 32'(mon_word), 32'hA5);
    check("t1_rise_count", 32'(rise_cnt), 32'd8);
    issue(2'd2, 8'h00);
    check("t1_cs_high", 32'(bp_cs), 32'd1);

    // 2: all four modes, div=3, loopback
    slave_en = 1'b0; cfg_div = 8'd3;
    for (int m = 0; m < 4; m++) begin
      cfg_cpol = m[1]; cfg_cpha = m[0];
      repeat (2) @(negedge clock);
      check("t2_idle_level", 32'(bp_clock), 32'(cfg_cpol));
      run_xfer("t2", 8'h81, 8'h81, 65, 4);
    end

    // 3: LSB first, slave sends 0x80 on the wire
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 8'd0; cfg_lsb_first = 1'b1;
    slave_en = 1'b1; slave_word = 8'h80;
    repeat (2) @(negedge clock);
    clear_mon();
    run_xfer("t3", 8'h01, 8'h01, 17, 1);
    check("t3_mon_first", 32'(mon_first), 32'd1);
    check("t3_mosi_word", 32'(mon_word), 32'h80);
    cfg_lsb_first = 1'b0; slave_en = 1'b0;

    // 4: response back-pressure with a transfer pending
    rsp_ready = 1'b0;
    sb_q.push_back(8'h5A);
    issue(2'd0, 8'h5A);
    cnt = 1;
    while (rsp_valid !== 1'b1 && cnt < 500) begin @(negedge clock); cnt++; end
    check("t4_latency", 32'(cnt), 32'd17);
    sb_q.push_back(8'hC3);
    cmd_op = 2'd0; cmd_data = 8'hC3; cmd_valid = 1'b1;
    ok_rdy = 1'b1; ok_dat = 1'b1;
    repeat (50) begin
      @(negedge clock);
      if (cmd_ready !== 1'b0) ok_rdy = 1'b0;
      if (rsp_data !== 8'h5A || rsp_valid !== 1'b1) ok_dat = 1'b0;
    end
    check("t4_stall_cmd_ready", 32'(ok_rdy), 32'd1);
    check("t4_stall_rsp_stable", 32'(ok_dat), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clock);
    check("t4_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t4_hs_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    cmd_valid = 1'b0;
    check("t4_second_busy", 32'(busy), 32'd1);
    cnt = 1;
    while (rsp_valid !== 1'b1 && cnt < 500) begin @(negedge clock); cnt++; end
    check("t4_second_latency", 32'(cnt), 32'd17);
    @(negedge clock);

    // 5: delay commands with CS held low
    issue(2'd1, 8'h00);
    @(negedge clock);
    cfg_div = 8'd1;
    issue(2'd3, 8'd5);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin cnt++; @(negedge clock); end
    check("t5_delay_n5", 32'(cnt), 32'd10);
    issue(2'd3, 8'd0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin cnt++; @(negedge clock); end
    check("t5_delay_n0", 32'(cnt), 32'd1);
    check("t5_cs_held", 32'(bp_cs), 32'd0);

    // 6: reset mid-transfer, then a clean transfer
    cfg_div = 8'd0;
    issue(2'd0, 8'hFF);
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t6_rst_cs", 32'(bp_cs), 32'd1);
    check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_rst_clock", 32'(bp_clock), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_xfer("t6", 8'h42, 8'h42, 17, 1);

    repeat (3) @(negedge clock);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
